shift_issue_ctrl: RTL

- Initiator side of the multi-cycle shifter's start/stalled handshake.
- Accepts one shift request at a time from decode over a valid/ready interface.
- Drives the shifter's operand and start inputs and holds them stable while the shifter stalls.
- Detects completion, then issues a one-cycle register-file writeback pulse. Also provides flush, a latency watchdog and a busy-cycle counter.

---
 rtl/shift_issue_ctrl_pkg.sv | 8 +
 rtl/shift_issue_watchdog.sv | 32 +++
 rtl/shift_issue_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/shift_issue_ctrl_pkg.sv
// shift_issue_ctrl_pkg: shared opcode, destination and FSM encodings for the shifter issue controller
package shift_issue_ctrl_pkg;
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b11;
  localparam logic [4:0] NOP_DST = 5'd0;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;
endpackage

// File: rtl/shift_issue_watchdog.sv
// shift_issue_watchdog: counts active cycles of a multi-cycle op and raises a sticky error at TIMEOUT
module shift_issue_watchdog #(
  parameter int TIMEOUT = 63
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic active,
  input  logic done,
  output logic expired,
  output logic err
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // expires on the TIMEOUT-th active cycle; a completion in that same cycle wins
  assign expired = active & ~done & (cnt_q == CW'(TIMEOUT - 1));
  assign err = err_q;
  always_comb begin
    cnt_d = clear ? '0 : (active & ~done & ~expired) ? cnt_q + 1'b1 : cnt_q;
    err_d = err_q | expired;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: issues one shift request at a time to the multi-cycle shifter and writes back its result
module shift_issue_ctrl
  import shift_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 63,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_opB,
  input  logic [4:0]       req_sa,
  input  logic [1:0]       req_op,
  input  logic [4:0]       req_dst,
  input  logic             flush,
  output logic             u_start,
  output logic [WIDTH-1:0] u_opB,
  output logic [4:0]       u_sa,
  output logic [1:0]       u_op,
  output logic [4:0]       u_dst,
  input  logic             u_stalled,
  input  logic [WIDTH-1:0] u_result,
  output logic             wb_valid,
  output logic [4:0]       wb_dst,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] perf_busy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] u_opB_q, u_opB_d, wb_data_q, wb_data_d;
  logic [4:0] u_sa_q, u_sa_d, u_dst_q, u_dst_d, wb_dst_q, wb_dst_d;
  logic [1:0] u_op_q, u_op_d;
  logic killed_q, killed_d, wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0] perf_q, perf_d;
  logic issue, accept, complete, expired;
  assign issue = state_q == ISSUE;
  assign accept = ~issue & req_valid & ~flush;
  assign complete = issue & ~u_stalled;
  shift_issue_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk), .resetn(resetn), .clear(accept), .active(issue),
    .done(~u_stalled), .expired(expired), .err(err_timeout)
  );
  always_comb begin
    state_d = accept ? ISSUE : (complete | expired) ? IDLE : state_q;
    u_opB_d = accept ? req_opB : u_opB_q;
    u_sa_d = accept ? req_sa : u_sa_q;
    u_op_d = accept ? req_op : u_op_q;
    u_dst_d = accept ? req_dst : u_dst_q;
    // a flush landing in the completion cycle itself still suppresses the writeback
    killed_d = accept ? 1'b0 : killed_q | (issue & flush);
    wb_valid_d = complete & (u_dst_q != NOP_DST) & ~killed_q & ~flush;
    wb_dst_d = complete ? u_dst_q : wb_dst_q;
    wb_data_d = complete ? u_result : wb_data_q;
    perf_d = perf_q + CNT_W'(issue & u_stalled);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      u_opB_q <= '0;
      u_sa_q <= '0;
      u_op_q <= '0;
      u_dst_q <= '0;
      killed_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_dst_q <= '0;
      wb_data_q <= '0;
      perf_q <= '0;
    end else begin
      state_q <= state_d;
      u_opB_q <= u_opB_d;
      u_sa_q <= u_sa_d;
      u_op_q <= u_op_d;
      u_dst_q <= u_dst_d;
      killed_q <= killed_d;
      wb_valid_q <= wb_valid_d;
      wb_dst_q <= wb_dst_d;
      wb_data_q <= wb_data_d;
      perf_q <= perf_d;
    end
  end
  assign req_ready = ~issue & ~flush;
  assign u_start = issue;
  assign busy = issue;
  assign u_opB = u_opB_q;
  assign u_sa = u_sa_q;
  assign u_op = u_op_q;
  assign u_dst = u_dst_q;
  assign wb_valid = wb_valid_q;
  assign wb_dst = wb_dst_q;
  assign wb_data = wb_data_q;
  assign perf_busy = perf_q;
endmodule
